// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor. Operands are latched once, then
//   streamed LSB nibble first through a single 4-bit carry-lookahead stage,
//   one nibble per clock. The nibble carry-out is registered and fed back as
//   the carry-in of the next nibble. Uses far less logic than a full-width
//   CLA tree, at the cost of WIDTH/4 cycles of latency.
//
// Ports
//   clk        in   1      clock, all state changes on posedge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand request valid
//   in_ready   out  1      request can be accepted (IDLE and not in reset)
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_sub     in   1      1: A-B, 0: A+B+in_cin
//   in_cin     in   1      carry-in for add, ignored for subtract
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer accepts the result
//   out_sum    out  WIDTH  result
//   out_cout   out  1      carry out of the MSB (subtract: 1 = no borrow)
//   out_ovf    out  1      signed two's-complement overflow
//   out_zero   out  1      out_sum == 0
//
// WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead adder slice.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = c0;
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s  = p ^ c[3:0];
    assign c4 = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;
    logic [WIDTH-1:0] sum_q;
    logic             ovf_q;

    logic             accept;
    logic             last_nib;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             nib_c4;

    assign accept   = in_valid & in_ready;
    assign last_nib = (k_q == K_LAST);

    // Nibble k occupies bits [4k+3:4k]; {k,2'b00} is 4k.
    assign nib_a = a_q[{k_q, 2'b00} +: 4];
    assign nib_b = bx_q[{k_q, 2'b00} +: 4];

    cla_4bit u_cla (
        .a  (nib_a),
        .b  (nib_b),
        .c0 (carry_q),
        .s  (nib_s),
        .c4 (nib_c4)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stray encodings fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs. in_ready is masked by rst so nothing is accepted
    // on the reset edge.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
    end

    // Operand latch: only written on acceptance, so the operands cannot be
    // disturbed while RUN/DONE.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= in_a;
            bx_q <= in_sub ? ~in_b : in_b;
        end
    end

    // Nibble sequencer and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // Subtract is A + ~B + 1, so the forced carry-in
                        // supplies the +1.
                        carry_q <= in_sub | in_cin;
                        k_q     <= '0;
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[{k_q, 2'b00} +: 4] <= nib_s;
                    carry_q                  <= nib_c4;
                    if (last_nib) begin
                        // Overflow: operands of equal sign giving a result
                        // of the opposite sign.
                        ovf_q <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) &
                                 (nib_s[3] != a_q[WIDTH-1]);
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result outputs; only meaningful while out_valid is high.
    assign out_sum  = sum_q;
    assign out_cout = carry_q;
    assign out_ovf  = ovf_q;
    assign out_zero = (sum_q == '0);
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_sub;
    logic        in_cin;
    logic        out_ready;

    logic        in_ready16, out_valid16, out_cout16, out_ovf16, out_zero16;
    logic [15:0] out_sum16;
    logic        in_ready8, out_valid8, out_cout8, out_ovf8, out_zero8;
    logic [7:0]  out_sum8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16),
        .out_cout(out_cout16), .out_ovf(out_ovf16), .out_zero(out_zero16)
    );

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
        .out_cout(out_cout8), .out_ovf(out_ovf8), .out_zero(out_zero8)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on a w-bit word.
    function automatic res_t ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                       input logic sub, input logic cin);
        res_t   r;
        longint m, half, ua, ubx, c0, tot, sa, sbx, st;
        m    = (longint'(1) << w) - 1;
        half = (m + 1) / 2;
        ua   = longint'(a) & m;
        ubx  = (sub ? ~longint'(b) : longint'(b)) & m;
        c0   = (sub || cin) ? 1 : 0;
        tot  = ua + ubx + c0;
        sa   = (ua  >= half) ? ua  - (m + 1) : ua;
        sbx  = (ubx >= half) ? ubx - (m + 1) : ubx;
        st   = sa + sbx + c0;
        r.sum  = 16'(tot & m);
        r.cout = ((tot >> w) != 0);
        r.ovf  = (st >= half) || (st < -half);
        r.zero = ((tot & m) == 0);
        return r;
    endfunction

    // Directed helpers (16-bit instance); all run at #1 after a posedge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic cin);
        int t = 0;
        while (!in_ready16 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("start_ready_timeout", 32'(in_ready16), 32'd1);
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid16 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    // Random-phase state
    res_t q16[$];
    res_t q8[$];
    int   n_sent, n_got16, n_got8, cyc;

    task automatic observe_cycle();
        res_t e;
        @(negedge clk);
        if (in_valid && in_ready16 && in_ready8) begin
            q16.push_back(ref_model(16, in_a, in_b, in_sub, in_cin));
            q8.push_back(ref_model(8, in_a, in_b, in_sub, in_cin));
            n_sent++;
        end
        if (out_valid16 && out_ready) begin
            if (q16.size() == 0) begin
                chk("r16_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                chk("r16_sum",  32'(out_sum16),  32'(e.sum));
                chk("r16_cout", 32'(out_cout16), 32'(e.cout));
                chk("r16_ovf",  32'(out_ovf16),  32'(e.ovf));
                chk("r16_zero", 32'(out_zero16), 32'(e.zero));
            end
            n_got16++;
        end
        if (out_valid8 && out_ready) begin
            if (q8.size() == 0) begin
                chk("r8_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                chk("r8_sum",  32'(out_sum8),  32'(e.sum[7:0]));
                chk("r8_cout", 32'(out_cout8), 32'(e.cout));
                chk("r8_ovf",  32'(out_ovf8),  32'(e.ovf));
                chk("r8_zero", 32'(out_zero8), 32'(e.zero));
            end
            n_got8++;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] corner [4];
        corner[0] = 16'h0000; corner[1] = 16'hFFFF;
        corner[2] = 16'h8000; corner[3] = 16'h7FFF;
        if (($urandom & 3) == 0) return corner[$urandom_range(3, 0)];
        return 16'($urandom);
    endfunction

    localparam int NRAND = 2000;

    initial begin
        vec_t        vecs [7];
        int          lat;
        int          stray;
        logic [15:0] held_sum;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_in_ready",  32'(in_ready16),  32'd0);
        chk("rst_out_valid", 32'(out_valid16), 32'd0);
        chk("rst_out_sum",   32'(out_sum16),   32'd0);
        chk("rst_out_cout",  32'(out_cout16),  32'd0);
        chk("rst_out_ovf",   32'(out_ovf16),   32'd0);
        chk("rst_out_zero",  32'(out_zero16),  32'd1);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready16), 32'd1);
        @(posedge clk); #1;

        // Table-driven directed vectors
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            wait_valid(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("v%0d_sum", i),  32'(out_sum16),  32'(vecs[i].sum));
            chk($sformatf("v%0d_cout", i), 32'(out_cout16), 32'(vecs[i].cout));
            chk($sformatf("v%0d_ovf", i),  32'(out_ovf16),  32'(vecs[i].ovf));
            chk($sformatf("v%0d_zero", i), 32'(out_zero16), 32'(vecs[i].zero));
            chk($sformatf("v%0d_busy_ready", i), 32'(in_ready16), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_drop", i), 32'(out_valid16), 32'd0);
            chk($sformatf("v%0d_idle_ready", i), 32'(in_ready16), 32'd1);
        end

        // Backpressure in DONE with a competing request
        out_ready = 1'b0;
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd4);
        held_sum = 16'h3333;
        in_a = 16'hAAAA; in_b = 16'h0101; in_sub = 1'b0; in_cin = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("bp_hold_valid", 32'(out_valid16), 32'd1);
            chk("bp_hold_sum",   32'(out_sum16),   32'(held_sum));
            chk("bp_hold_flags", 32'({out_cout16, out_ovf16, out_zero16}), 32'd0);
            chk("bp_in_ready",   32'(in_ready16),  32'd0);
            @(posedge clk); #1;
        end
        // Release with in_valid still high: the DONE->IDLE edge must not accept.
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid16), 32'd0);
        chk("bp_release_ready", 32'(in_ready16),  32'd1);
        chk("bp_release_sum",   32'(out_sum16),   32'(held_sum));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_new_latency", 32'(lat), 32'd4);
        chk("bp_new_sum", 32'(out_sum16), 32'h0000ABAB);
        @(posedge clk); #1;

        // Reset during RUN at k=2
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstrun_valid",    32'(out_valid16), 32'd0);
        chk("rstrun_sum",      32'(out_sum16),   32'd0);
        chk("rstrun_zero",     32'(out_zero16),  32'd1);
        chk("rstrun_ready_in_rst", 32'(in_ready16), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstrun_ready", 32'(in_ready16), 32'd1);
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid16 || out_valid8) stray++;
        end
        chk("rstrun_no_stray_valid", 32'(stray), 32'd0);

        // Randomised traffic on both widths against the reference model
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_sent = 0; n_got16 = 0; n_got8 = 0; cyc = 0;
        while ((n_got16 < NRAND || n_got8 < NRAND) && cyc < 60000) begin
            out_ready = (($urandom % 3) != 0);
            if (in_valid) begin
                in_valid = 1'b0;
            end else if (n_sent < NRAND && in_ready16 && in_ready8 && (($urandom & 1) != 0)) begin
                in_a   = pick_operand();
                in_b   = pick_operand();
                in_sub = 1'($urandom & 1);
                in_cin = 1'($urandom & 1);
                in_valid = 1'b1;
            end
            observe_cycle();
        end
        chk("rand_done16", 32'(n_got16), 32'(NRAND));
        chk("rand_done8",  32'(n_got8),  32'(NRAND));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
